// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor.
// One full-adder cell and a carry flip-flop process one bit per clock, LSB first.
// Subtraction is a + ~b + 1: B is inverted on capture and the carry is seeded with 1.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request; only sampled in idle or done
//   sub       0 = a+b, 1 = a-b; captured with start
//   a, b      operands; captured with start
//   busy      high while bits are being shifted (exactly WIDTH cycles)
//   done      one-cycle pulse; sum/cout/overflow valid
//   sum       result modulo 2^WIDTH; held until the next accepted start
//   cout      carry out of MSB (subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CountW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {st_idle, st_shift, st_done} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                carry_q;
  logic [CountW-1:0]   count_q;
  logic                s_bit;
  logic                c_bit;

  // The single full-adder cell.
  always_comb begin
    s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    c_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= st_idle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        st_idle, st_done: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub;
            count_q  <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state_q  <= st_shift;
          end else begin
            state_q <= st_idle;
          end
        end
        st_shift: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum     <= {s_bit, sum[WIDTH-1:1]};
          carry_q <= c_bit;
          count_q <= count_q + CountW'(1);
          if (count_q == CountW'(WIDTH - 1)) begin
            // carry_q here is the carry into the MSB.
            cout     <= c_bit;
            overflow <= carry_q ^ c_bit;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= st_done;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= st_idle;
        end
      endcase
    end
  end

endmodule
